// File: rtl/hedios_dispatch_pkg.sv
// Shared types and constants for the HEDIOS RX command dispatcher and its helpers.
package hedios_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_OFFER = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  localparam int TGT_FIELD_HI = 7;
  localparam int TGT_FIELD_LO = 4;

  localparam int              ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

  typedef struct packed {
    logic [7:0]  command;
    logic [31:0] data;
  } packet_t;

  function automatic logic [3:0] tgt_index(input logic [7:0] cmd);
    return cmd[TGT_FIELD_HI:TGT_FIELD_LO];
  endfunction

endpackage

// File: rtl/hedios_timeout_timer.sv
// Bounded wait counter: counts enabled cycles and parks at TIMEOUT_CYCLES-1 (never wraps).
module hedios_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/hedios_cmd_dispatcher.sv
// Drains the HEDIOS RX packet queue and offers each packet to the endpoint named by
// the command's upper nibble, with a bounded handshake plus delivery/error counters.
module hedios_cmd_dispatcher
  import hedios_dispatch_pkg::*;
#(
  parameter int NUM_TARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear_counts,
  input  logic                   queue_empty,
  output logic                   pop_packet,
  input  logic [7:0]             packet_command,
  input  logic [31:0]            packet_data,
  output logic [NUM_TARGETS-1:0] tgt_valid,
  input  logic [NUM_TARGETS-1:0] tgt_ready,
  output logic [7:0]             tgt_command,
  output logic [31:0]            tgt_data,
  output logic                   busy,
  output logic                   bad_target_pulse,
  output logic                   timeout_pulse,
  output logic [CNT_W-1:0]       dispatch_count,
  output logic [ERR_W-1:0]       error_count
);

  state_e     state, state_nxt;
  logic [3:0] idx;
  logic       in_range, offering, xfer;
  logic       timer_clr, timer_en, tmo_expired, timeout_ev, drop_ev;

  assign idx      = tgt_index(tgt_command);
  assign in_range = {1'b0, tgt_index(packet_command)} < 5'(NUM_TARGETS);
  // Only the selected lane can have valid high, so this ignores other readies.
  assign xfer     = |(tgt_valid & tgt_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable && !queue_empty) state_nxt = ST_POP;
      ST_POP:   state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = in_range ? ST_OFFER : ST_DROP;
      ST_OFFER: if (xfer || tmo_expired) state_nxt = ST_IDLE;
      ST_DROP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_packet = (state == ST_POP);
    busy       = (state != ST_IDLE);
    offering   = (state == ST_OFFER);
    timer_clr  = (state == ST_LATCH);
    timer_en   = offering && !xfer;
    // A ready on the final cycle wins over the timeout.
    timeout_ev = offering && !xfer && tmo_expired;
    drop_ev    = (state == ST_DROP) || timeout_ev;
  end

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_valid
    assign tgt_valid[i] = offering && (idx == 4'(i));
  end

  hedios_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_command <= '0;
      tgt_data    <= '0;
    end else if (state == ST_LATCH) begin
      tgt_command <= packet_command;
      tgt_data    <= packet_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_target_pulse <= 1'b0;
      timeout_pulse    <= 1'b0;
      dispatch_count   <= '0;
      error_count      <= '0;
    end else begin
      bad_target_pulse <= (state == ST_DROP);
      timeout_pulse    <= timeout_ev;
      if (clear_counts)         dispatch_count <= '0;
      else if (offering && xfer) dispatch_count <= dispatch_count + 1'b1;
      if (clear_counts)                         error_count <= '0;
      else if (drop_ev && error_count != ERR_SAT) error_count <= error_count + 1'b1;
    end
  end

endmodule
